// File: rtl/bb_row_loader.sv
// Row fetcher for the bank buffer: assembles SRAM beats into full rows,
// pushes them into the 3-row shifter and offers each resident window to the MAC.
module bb_row_loader #(
    parameter int FXP          = 6,
    parameter int BB_REG_WIDTH = 36,
    parameter int MAC_CN_HGT   = 3,
    parameter int MEM_PIX      = 4,
    parameter int ADDR_W       = 12,
    parameter int ROW_W        = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [ROW_W-1:0]            num_rows,
    input  logic                        roi_sel,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [MEM_PIX*FXP-1:0]      mem_rdata,
    input  logic                        mem_rvalid,
    output logic                        bb_clr,
    output logic                        bb_en,
    output logic [BB_REG_WIDTH*FXP-1:0] bb_val,
    output logic                        bb_roi_lb_r,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int BEATS  = BB_REG_WIDTH / MEM_PIX;
    localparam int BW     = MEM_PIX * FXP;
    localparam int VW     = BB_REG_WIDTH * FXP;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int FILL_W = $clog2(MAC_CN_HGT + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(MAC_CN_HGT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_WIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ROW_W-1:0]    nrows_q, nrows_d;
    logic                roi_q, roi_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                bb_clr_q, bb_clr_d;
    logic                bb_en_q, bb_en_d;
    logic [VW-1:0]       bb_val_q, bb_val_d;
    logic                win_valid_q, win_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        nrows_d  = nrows_q;
        roi_d    = roi_q;
        row_d    = row_q;
        fill_d   = fill_q;
        beat_d   = beat_q;
        ptr_d    = ptr_q;
        bb_val_d = bb_val_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    nrows_d = num_rows;
                    roi_d   = roi_sel;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                row_d   = '0;
                fill_d  = '0;
                beat_d  = '0;
                ptr_d   = base_q;
                state_d = (nrows_q == '0) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                // ptr tracks base + row*BEATS + beat, wrapping at ADDR_W
                ptr_d   = ptr_q + ADDR_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_q == BEAT_W'(b)) begin
                            bb_val_d[b*BW +: BW] = mem_rdata;
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_PUSH;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_PUSH: begin
                row_d  = row_q + ROW_W'(1);
                fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
                if (fill_d == FILL_MAX) begin
                    state_d = S_WIN;
                end else if (row_d == nrows_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WIN: begin
                if (win_valid_q && win_ready) begin
                    state_d = (row_q == nrows_q) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of the state being entered
        mem_req_d   = (state_d == S_REQ);
        mem_addr_d  = (state_d == S_REQ) ? ptr_d : mem_addr_q;
        bb_clr_d    = (state_d == S_CLR);
        bb_en_d     = (state_d == S_PUSH);
        win_valid_d = (state_d == S_WIN);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            nrows_q     <= '0;
            roi_q       <= 1'b0;
            row_q       <= '0;
            fill_q      <= '0;
            beat_q      <= '0;
            ptr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            bb_clr_q    <= 1'b0;
            bb_en_q     <= 1'b0;
            bb_val_q    <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            nrows_q     <= nrows_d;
            roi_q       <= roi_d;
            row_q       <= row_d;
            fill_q      <= fill_d;
            beat_q      <= beat_d;
            ptr_q       <= ptr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            bb_clr_q    <= bb_clr_d;
            bb_en_q     <= bb_en_d;
            bb_val_q    <= bb_val_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign bb_clr      = bb_clr_q;
    assign bb_en       = bb_en_q;
    assign bb_val      = bb_val_q;
    assign bb_roi_lb_r = roi_q;
    assign win_valid   = win_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_bb_row_loader.sv
// Bench for bb_row_loader: table of jobs checked by an address/row scoreboard,
// plus hand-written backpressure and mid-job reset sequences.
module tb_bb_row_loader;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [11:0]  base_addr;
    logic [7:0]   num_rows;
    logic         roi_sel;
    logic         mem_req;
    logic [11:0]  mem_addr;
    logic [23:0]  mem_rdata;
    logic         mem_rvalid;
    logic         bb_clr;
    logic         bb_en;
    logic [215:0] bb_val;
    logic         bb_roi_lb_r;
    logic         win_valid;
    logic         win_ready;
    logic         busy;
    logic         done;

    bb_row_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_addr(base_addr), .num_rows(num_rows), .roi_sel(roi_sel),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .bb_clr(bb_clr), .bb_en(bb_en), .bb_val(bb_val),
        .bb_roi_lb_r(bb_roi_lb_r),
        .win_valid(win_valid), .win_ready(win_ready),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_fail = 0;

    int pat = 0;
    int lat_max = 1;
    bit spur = 0;
    logic [11:0] job_base = '0;

    logic [11:0]  exp_addr[$];
    logic [215:0] exp_row[$];
    int req_cnt, en_cnt, clr_cnt, win_cnt, done_cnt;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] word(input logic [11:0] a);
        logic [23:0] w;
        logic [11:0] d;
        d = a - job_base;
        for (int k = 0; k < 4; k++) begin
            if (pat == 0) w[k*6 +: 6] = 6'(d % 12'd9);
            else          w[k*6 +: 6] = a[5:0] ^ a[11:6] ^ 6'(k * 11);
        end
        return w;
    endfunction

    // Memory model: one response per request, latency 1..lat_max
    initial begin
        int lat;
        logic [11:0] a;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                a = mem_addr;
                lat = $urandom_range(lat_max, 1);
                if (spur) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 24'hA5C3E1;
                end
                @(posedge clk);
                #1 mem_rvalid = 1'b0;
                repeat (lat - 1) @(posedge clk);
                if (lat > 1) #1;
                mem_rvalid = 1'b1;
                mem_rdata  = word(a);
                @(posedge clk);
                #1 mem_rvalid = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req) begin
                    req_cnt++;
                    if (exp_addr.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL extra_req: got addr %0h expected no request", mem_addr);
                    end else begin
                        chk("mem_addr", mem_addr, exp_addr.pop_front());
                    end
                end
                if (bb_en) begin
                    en_cnt++;
                    if (exp_row.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL extra_bb_en: got row %0h expected no push", bb_val);
                    end else begin
                        chk("bb_val_row", bb_val, exp_row.pop_front());
                    end
                end
                if (bb_clr) clr_cnt++;
                if (win_valid && win_ready) win_cnt++;
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic start_job(input int nr, input logic [11:0] base, input logic roi);
        logic [215:0] row;
        logic [11:0] a;
        job_base = base;
        exp_addr.delete();
        exp_row.delete();
        req_cnt = 0; en_cnt = 0; clr_cnt = 0; win_cnt = 0; done_cnt = 0;
        for (int r = 0; r < nr; r++) begin
            for (int b = 0; b < 9; b++) begin
                a = base + 12'(r * 9 + b);
                exp_addr.push_back(a);
                row[b*24 +: 24] = word(a);
            end
            exp_row.push_back(row);
        end
        @(posedge clk);
        #1;
        base_addr = base;
        num_rows  = 8'(nr);
        roi_sel   = roi;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_job(input int er, input int ee, input int ew, input logic roi);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 32'(done_cnt != 0), 1);
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("req_count", req_cnt, er);
        chk("en_count", en_cnt, ee);
        chk("win_count", win_cnt, ew);
        chk("clr_count", clr_cnt, 1);
        chk("done_count", done_cnt, 1);
        chk("addr_left", exp_addr.size(), 0);
        chk("roi_latched", bb_roi_lb_r, roi);
    endtask

    task automatic chk_reset_outs();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_bb_clr", bb_clr, 0);
        chk("rst_bb_en", bb_en, 0);
        chk("rst_bb_val", bb_val, 0);
        chk("rst_roi", bb_roi_lb_r, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    typedef struct {
        int         nr;
        logic [11:0] base;
        logic       roi;
        int         lat;
        bit         spur;
        int         pat;
        bit         midstart;
        int         er;
        int         ee;
        int         ew;
    } job_t;

    job_t jobs[5];

    initial begin
        logic [215:0] hold;
        int cyc;
        jobs[0] = '{5, 12'h100, 1'b0, 1, 1'b0, 0, 1'b0, 45, 5, 3};
        jobs[1] = '{2, 12'h200, 1'b1, 1, 1'b0, 0, 1'b0, 18, 2, 0};
        jobs[2] = '{0, 12'h300, 1'b0, 1, 1'b0, 0, 1'b0, 0, 0, 0};
        jobs[3] = '{5, 12'h100, 1'b0, 4, 1'b1, 1, 1'b1, 45, 5, 3};
        jobs[4] = '{4, 12'hFF0, 1'b1, 2, 1'b0, 1, 1'b0, 36, 4, 2};

        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_rows = '0;
        roi_sel = 1'b0;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            pat = jobs[i].pat;
            lat_max = jobs[i].lat;
            spur = jobs[i].spur;
            start_job(jobs[i].nr, jobs[i].base, jobs[i].roi);
            if (jobs[i].midstart) begin
                cyc = 0;
                while (en_cnt == 0 && cyc < 1000) begin
                    @(negedge clk);
                    cyc++;
                end
                @(posedge clk);
                #1;
                base_addr = 12'h7A0;
                num_rows  = 8'd1;
                roi_sel   = ~jobs[i].roi;
                start     = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            finish_job(jobs[i].er, jobs[i].ee, jobs[i].ew, jobs[i].roi);
            spur = 0;
        end

        // Backpressure at the first window
        pat = 0;
        lat_max = 1;
        win_ready = 1'b0;
        start_job(5, 12'h100, 1'b0);
        cyc = 0;
        while (!win_valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_win_seen", win_valid, 1);
        hold = bb_val;
        for (int i = 0; i < 10; i++) begin
            chk("bp_win_valid", win_valid, 1);
            chk("bp_no_req", mem_req, 0);
            chk("bp_no_en", bb_en, 0);
            chk("bp_val_stable", bb_val, hold);
            @(negedge clk);
        end
        @(posedge clk);
        #1 win_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_resume_req", mem_req, 1);
        chk("bp_win_drop", win_valid, 0);
        finish_job(45, 5, 3, 1'b0);

        // Reset during the third row's first WAIT
        start_job(5, 12'h100, 1'b1);
        cyc = 0;
        while (en_cnt < 2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        cyc = 0;
        while (!mem_req && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_row3_req", mem_addr, 12'h112);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs();

        start_job(5, 12'h140, 1'b0);
        finish_job(45, 5, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
